// File: rtl/axis_i2s_playback.sv
// AXI4-Stream to I2S playback stage: queues 64-bit stereo frames and shifts them
// out on ac_pbdat, slaved to the codec's bit clock and LR clock.
module axis_i2s_playback #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             s_axis_aclk,
  input  logic                             s_axis_aresetn,
  input  logic                             playback_en,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic [63:0]                      s_axis_tdata,
  input  logic                             ac_bclk,
  input  logic                             ac_pblrc,
  output logic                             ac_pbdat,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             underrun_pulse,
  output logic [15:0]                      underrun_count,
  input  logic                             underrun_clear
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);

  logic [SYNC_STAGES-1:0] r_bclkSync;
  logic [SYNC_STAGES-1:0] r_lrSync;
  logic                   r_bclkPrev;
  logic                   r_lrQ;
  logic [63:0]            r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wrPtr;
  logic [AW-1:0]          r_rdPtr;
  logic [LW-1:0]          r_level;
  logic                   r_rstDone;
  logic [63:0]            r_frame;
  logic [31:0]            r_shift;
  logic                   r_loadPending;
  logic                   r_pbdat;
  logic                   r_underrunPulse;
  logic [15:0]            r_underrunCount;

  logic        w_bclkFall;
  logic        w_lrSync;
  logic        w_change;
  logic        w_fetch;
  logic        w_push;
  logic        w_pop;
  logic        w_underrun;
  logic [31:0] w_slot;

  assign w_bclkFall = r_bclkPrev & ~r_bclkSync[SYNC_STAGES-1];
  assign w_lrSync   = r_lrSync[SYNC_STAGES-1];
  assign w_change   = w_bclkFall && (w_lrSync != r_lrQ);
  // A new frame is fetched only at the start of the left phase; the right slot reuses it.
  assign w_fetch    = w_change && !w_lrSync && playback_en;
  assign w_pop      = w_fetch && (r_level != '0);
  assign w_underrun = w_fetch && (r_level == '0);
  assign w_push     = s_axis_tvalid && s_axis_tready;
  assign w_slot     = r_lrQ ? r_frame[31:0] : r_frame[63:32];

  assign s_axis_tready  = r_rstDone && playback_en && (r_level < LW'(FIFO_DEPTH));
  assign ac_pbdat       = r_pbdat;
  assign fifo_level     = r_level;
  assign underrun_pulse = r_underrunPulse;
  assign underrun_count = r_underrunCount;

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_bclkSync <= '0;
      r_lrSync   <= '0;
      r_bclkPrev <= 1'b0;
      r_lrQ      <= 1'b0;
      r_rstDone  <= 1'b0;
    end else begin
      r_bclkSync <= {r_bclkSync[SYNC_STAGES-2:0], ac_bclk};
      r_lrSync   <= {r_lrSync[SYNC_STAGES-2:0], ac_pblrc};
      r_bclkPrev <= r_bclkSync[SYNC_STAGES-1];
      r_rstDone  <= 1'b1;
      if (w_bclkFall) r_lrQ <= w_lrSync;
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (w_push) r_mem[r_wrPtr] <= s_axis_tdata;
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else if (!playback_en) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // The MSB goes out one bclk after the LR change, so the change bit carries the previous LSB.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_frame       <= '0;
      r_shift       <= '0;
      r_loadPending <= 1'b0;
      r_pbdat       <= 1'b0;
    end else if (!playback_en) begin
      r_frame       <= '0;
      r_shift       <= '0;
      r_loadPending <= 1'b0;
      r_pbdat       <= 1'b0;
    end else begin
      if (w_fetch) r_frame <= w_pop ? r_mem[r_rdPtr] : 64'd0;
      if (w_bclkFall) begin
        if (r_loadPending && !w_change) begin
          r_loadPending <= 1'b0;
          r_pbdat       <= w_slot[31];
          r_shift       <= {w_slot[30:0], 1'b0};
        end else begin
          r_loadPending <= w_change;
          r_pbdat       <= r_shift[31];
          r_shift       <= {r_shift[30:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_underrunPulse <= 1'b0;
      r_underrunCount <= '0;
    end else begin
      r_underrunPulse <= w_underrun;
      if (underrun_clear)
        r_underrunCount <= '0;
      else if (w_underrun && (r_underrunCount != 16'hFFFF))
        r_underrunCount <= r_underrunCount + 16'd1;
    end
  end

endmodule
